// File: rtl/merge5_if.sv
// merge5_if: child-to-parent merge channel bundle (two input channels, one tagged output channel).
interface merge5_if #(parameter int W = 9);
  logic [W-1:0] in0_data, in1_data, out_data;
  logic in0_valid, in0_ready, in1_valid, in1_ready;
  logic s_data, out_valid, out_ready;
  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input in0_ready, in1_ready, out_data, s_data, out_valid
  );
  modport slave (
    input in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, s_data, out_valid
  );
endinterface

// File: rtl/merge5_node.sv
// merge5_node: 2:1 merge into one tagged output register slot; MERGE5_NODE_RR_EN selects round-robin over fixed In0 priority.
module merge5_node #(parameter int W = 9) (
  input logic clk,
  input logic rst,
  merge5_if.slave bus
);
  logic can_load, gnt0, gnt1, take;
  logic [W-1:0] data_q;
  logic tag_q, valid_q;
`ifdef MERGE5_NODE_RR_EN
  logic ptr;
  always_comb gnt1 = bus.in1_valid && (!bus.in0_valid || ptr);
  // pointer names the input preferred at the next contention
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (take) ptr <= gnt0;
`else
  always_comb gnt1 = bus.in1_valid && !bus.in0_valid;
`endif
  always_comb begin
    can_load = !valid_q || bus.out_ready;
    gnt0 = bus.in0_valid && !gnt1;
    take = !rst && can_load && (gnt0 || gnt1);
    bus.in0_ready = !rst && can_load && gnt0;
    bus.in1_ready = !rst && can_load && gnt1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      tag_q <= 1'b0;
    end else if (can_load) begin
      valid_q <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        data_q <= gnt1 ? bus.in1_data : bus.in0_data;
        tag_q <= gnt1;
      end
    end
  assign bus.out_data = data_q;
  assign bus.s_data = tag_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_merge5_node.sv
// tb_merge5_node: directed scenarios plus randomized traffic against a transaction-level merge model.
module tb_merge5_node;
  localparam int W = 9;
`ifdef MERGE5_NODE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  merge5_if #(.W(W)) bus ();
  merge5_node #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic idle();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0_data = '0;
    bus.in1_data = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.in0_data = 9'h1FF;
    bus.in1_data = 9'h1EE;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.s_data} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h s=%b exp 0", bus.out_valid, bus.out_data, bus.s_data);
    end
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_readies got %b%b exp 00", bus.in0_ready, bus.in1_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got v=%b exp 0", bus.out_valid);
    end
    do_reset();
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.in0_valid = 1'b1;
    bus.in0_data = 9'h1A5;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready got %b%b exp 10", bus.in0_ready, bus.in1_ready);
    end
    @(negedge clk);
    bus.in0_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.s_data} !== {1'b1, 9'h1A5, 1'b0}) begin
      errors++;
      $display("FAIL single_out got v=%b d=%h s=%b exp 1 1a5 0", bus.out_valid, bus.out_data, bus.s_data);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got v=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] ed;
    logic es;
    do_reset();
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.in0_data = 9'h011;
    bus.in1_data = 9'h122;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      es = RR ? k[0] : 1'b0;
      ed = es ? 9'h122 : 9'h011;
      checks++;
      if ({bus.out_valid, bus.out_data, bus.s_data} !== {1'b1, ed, es}) begin
        errors++;
        $display("FAIL contention_%0d got v=%b d=%h s=%b exp 1 %h %b", k, bus.out_valid, bus.out_data, bus.s_data, ed, es);
      end
    end
    idle();
  endtask

  task automatic test_stall();
    do_reset();
    bus.in0_valid = 1'b1;
    bus.in0_data = 9'h0AA;
    @(negedge clk);
    bus.in0_data = 9'h055;
    bus.in1_valid = 1'b1;
    bus.in1_data = 9'h1BB;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({bus.out_valid, bus.out_data, bus.s_data, bus.in0_ready, bus.in1_ready} !== {1'b1, 9'h0AA, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL stall_%0d got v=%b d=%h s=%b r=%b%b exp 1 0aa 0 00", k, bus.out_valid, bus.out_data, bus.s_data, bus.in0_ready, bus.in1_ready);
      end
      @(negedge clk);
    end
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL stall_release_ready got %b%b exp 10", bus.in0_ready, bus.in1_ready);
    end
    @(negedge clk);
    bus.in0_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.s_data} !== {1'b1, 9'h055, 1'b0}) begin
      errors++;
      $display("FAIL stall_next got v=%b d=%h s=%b exp 1 055 0", bus.out_valid, bus.out_data, bus.s_data);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ed;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        ed = 9'h100 + 9'(i - 1);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.s_data} !== {1'b1, ed, 1'b1}) begin
          errors++;
          $display("FAIL b2b_out_%0d got v=%b d=%h s=%b exp 1 %h 1", i - 1, bus.out_valid, bus.out_data, bus.s_data, ed);
        end
      end
      if (i < 4) begin
        bus.in1_valid = 1'b1;
        bus.in1_data = 9'h100 + 9'(i);
        #1;
        checks++;
        if (bus.in1_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_%0d got %b exp 1", i, bus.in1_ready);
        end
      end else bus.in1_valid = 1'b0;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in1_valid = 1'b1;
    bus.in1_data = 9'h0FF;
    @(negedge clk);
    bus.in1_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data} !== 10'b0) begin
      errors++;
      $display("FAIL midreset_drop got v=%b d=%h exp 0 000", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    bus.in0_data = 9'h011;
    bus.in1_data = 9'h122;
    #1;
    checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_grant got %b%b exp 10", bus.in0_ready, bus.in1_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_data, bus.s_data} !== {1'b1, 9'h011, 1'b0}) begin
      errors++;
      $display("FAIL midreset_out got v=%b d=%h s=%b exp 1 011 0", bus.out_valid, bus.out_data, bus.s_data);
    end
    idle();
  endtask

  task automatic test_random();
    logic [W-1:0] q0[$], q1[$], out_q[$];
    logic tag_q[$];
    logic v0, v1, pref1, want1, can, rdy;
    int bad = 0;
    do_reset();
    pref1 = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (out_q.size() > 0 && (bus.out_valid !== 1'b1 || bus.out_data !== out_q[0] || bus.s_data !== tag_q[0])) bad++;
      if (out_q.size() == 0 && bus.out_valid !== 1'b0) bad++;
      if (!v0 && $urandom_range(0, 2) != 0) begin
        q0.push_back(9'($urandom));
        v0 = 1'b1;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        q1.push_back(9'($urandom));
        v1 = 1'b1;
      end
      rdy = $urandom_range(0, 3) != 0;
      bus.in0_valid = v0;
      bus.in1_valid = v1;
      bus.in0_data = v0 ? q0[0] : 9'($urandom);
      bus.in1_data = v1 ? q1[0] : 9'($urandom);
      bus.out_ready = rdy;
      #1;
      can = out_q.size() == 0 || rdy;
      want1 = v1 && (!v0 || (RR && pref1));
      if (bus.in0_ready !== (can && v0 && !want1) || bus.in1_ready !== (can && want1)) bad++;
      if (can && out_q.size() > 0) begin
        void'(out_q.pop_front());
        void'(tag_q.pop_front());
      end
      if (can && (v0 || v1)) begin
        out_q.push_back(want1 ? q1.pop_front() : q0.pop_front());
        tag_q.push_back(want1);
        if (want1) v1 = 1'b0;
        else v0 = 1'b0;
        pref1 = !want1;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL random_traffic got %0d bad cycles exp 0", bad);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/merge5_node.md
MERGE5_NODE -- requirements
Module: merge5_node

Interface
REQ-001: Parameter W, default 9, packet width in bits; bits [8:5] carry the 4-bit destination address and pass through unmodified.
REQ-002: CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003: RESET  input  1  asynchronous, active-high reset.
REQ-004: In0_data  input  W  packet from child 0.
REQ-005: In0_valid  input  1  child 0 offers a packet.
REQ-006: In0_ready  output  1  child 0 packet is accepted this cycle.
REQ-007: In1_data, In1_valid, In1_ready  input/input/output  W/1/1  same as In0_* for child 1.
REQ-008: Out_data  output  W  merged packet toward the parent.
REQ-009: S_data  output  1  source tag of Out_data: 0 for In0, 1 for In1.
REQ-010: Out_valid  output  1  Out_data and S_data are valid.
REQ-011: Out_ready  input  1  parent accepts Out_data and S_data.

Function
REQ-012: The block SHALL merge the two upward child channels into one parent channel through a single output register stage, with latency 1 cycle from input acceptance to Out_valid.
REQ-013: A transfer on any channel SHALL occur on a rising edge where valid and ready are both 1.
REQ-014: Out_data and S_data SHALL be stored as one register pair, so the tag always matches its packet.
REQ-015: Slot state: EMPTY (Out_valid=0) or FULL (Out_valid=1).
- EMPTY -> FULL on an input acceptance.
- FULL -> EMPTY on an output transfer with no acceptance.
- FULL stays FULL when an output transfer and an acceptance occur in the same cycle.
REQ-016: can_load = !Out_valid || Out_ready; this is combinational.
REQ-017: At most one input ready SHALL be 1 per cycle, and only when can_load=1 and that input's valid=1.
- Input ready is driven combinationally from the valids, the grant pointer and can_load.
REQ-018: While Out_valid=1 and Out_ready=0, Out_data and S_data SHALL hold stable and both input readies SHALL be 0.
REQ-019: If only one input is valid, that input SHALL be granted whenever can_load=1.
REQ-020: If both inputs are valid, the winner SHALL be selected by the arbitration policy (REQ-026/027).
REQ-021: Packet contents SHALL pass bit-exact, with no reordering within a single input.
REQ-022: The input valids SHALL NOT depend combinationally on the input readies, so there is no combinational loop.
REQ-023: Sustained throughput SHALL be 1 packet per cycle while Out_ready=1.

Reset
REQ-024: While RESET=1, asynchronously:
- Out_valid=0, Out_data=0, S_data=0.
- Grant pointer = In0.
- In0_ready and In1_ready = 0.
REQ-025: When RESET is asserted mid-operation, a packet held in the slot SHALL be discarded.
- No partial transfer is reported.
- Operation resumes on the first rising edge after RESET deasserts.

Configuration
REQ-026: With MERGE5_NODE_RR_EN defined:
- Round-robin arbitration; a 1-bit pointer names the preferred input.
- After each acceptance, the pointer moves to the input that was not granted.
- Under continuous contention, grants SHALL alternate In0, In1, In0, ...
REQ-027: Without MERGE5_NODE_RR_EN:
- Fixed priority; In0 always wins contention.
- The pointer register SHALL not exist.

Verification
REQ-028: Only In0_valid=1, data=9'h1A5, Out_ready=1 -> one cycle later Out_valid=1, Out_data=9'h1A5, S_data=0.
REQ-029: Both inputs valid continuously (In0=9'h011, In1=9'h122), Out_ready=1:
- RR_EN -> Out_data sequence 011,122,011,122 with S_data 0,1,0,1.
- No RR_EN -> all outputs 011 with S_data=0.
REQ-030: Slot FULL and Out_ready held 0 for 5 cycles -> Out_data/S_data constant and both readies 0; then Out_ready=1 -> the next input is accepted in that same cycle.
REQ-031: Only In1_valid=1, 4 back-to-back packets 9'h100..9'h103, Out_ready=1 -> 4 outputs on consecutive cycles, all with S_data=1.
REQ-032: RESET pulsed while slot FULL with 9'h0FF -> Out_valid falls immediately, 9'h0FF is never delivered, and the first post-reset contention grants In0.
